// File: rtl/fpio_tx_arb_pkg.sv
// fpio_pkg: shared types, defaults and the round-robin pick helper for the fpio arbiters
package fpio_pkg;
  typedef enum logic {IDLE, XFER} fpio_arb_state_e;
  localparam int FPIO_CNT_WIDTH = 8;
  localparam int RR_MAX = 8;
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;
  function automatic int src_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Walks offsets from the far end back toward the pointer so the nearest
  // eligible index at or after ptr is the one left standing.
  function automatic rr_pick_t rr_pick(logic [RR_MAX-1:0] eligible, logic [2:0] ptr, int n);
    rr_pick_t r;
    int j;
    r = '0;
    for (int k = n - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % n;
      if (eligible[j]) begin
        r.found = 1'b1;
        r.idx   = 3'(j);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/fpio_tx_arb_if.sv
// fpio_tx_arb_if: requester streams in, single transmit stream out
//   req_valid/req_data/req_last/req_ready : per-requester beat handshake
//   tx_valid/tx_data/tx_last/tx_ready     : beat handshake toward fpio_tx
//   tx_src                                : index of the requester owning the link
//   master = arbiter side, slave = sources/transmitter side
interface fpio_tx_arb_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 4
);
  localparam int SW = fpio_pkg::src_w(N_REQ);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ-1:0]            req_ready;
  logic                        tx_valid;
  logic [DATA_WIDTH-1:0]       tx_data;
  logic                        tx_last;
  logic                        tx_ready;
  logic [SW-1:0]               tx_src;
  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, tx_last, tx_src
  );
  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, tx_last, tx_src
  );
endinterface

// File: rtl/fpio_tx_arb_rr_pick.sv
// fpio_rr_pick: first eligible index at or after the pointer, wrapping modulo N_REQ
//   i_eligible : candidate vector, i_ptr : search start
//   o_idx      : chosen index,     o_found : any candidate present
module fpio_rr_pick import fpio_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int SW    = src_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_eligible,
  input  logic [SW-1:0]    i_ptr,
  output logic [SW-1:0]    o_idx,
  output logic             o_found
);
  rr_pick_t w_pick;
  assign w_pick  = rr_pick(RR_MAX'(i_eligible), 3'(i_ptr), N_REQ);
  assign o_idx   = SW'(w_pick.idx);
  assign o_found = w_pick.found;
endmodule

// File: rtl/fpio_tx_arb.sv
// fpio_tx_arb: round-robin burst arbiter feeding the fpio transmit datapath
//   clk, rstn   : clock, asynchronous active-low reset
//   enable      : low blocks new grants (an active burst still completes)
//   burst_limit : max beats per grant, 0 = unlimited, snapshotted at grant
//   req_mask    : per-requester eligibility
//   busy        : a grant is active
//   bus         : requester and transmitter handshakes plus tx_src
module fpio_tx_arb import fpio_pkg::*; #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = FPIO_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] burst_limit,
  input  logic [N_REQ-1:0]     req_mask,
  output logic                 busy,
  fpio_tx_arb_if.master        bus
);
  localparam int SW = src_w(N_REQ);
  fpio_arb_state_e      r_state, w_next;
  logic [SW-1:0]        r_grant, r_ptr, w_pick;
  logic                 w_found, w_limit_hit;
  logic [CNT_WIDTH-1:0] r_cnt, r_limit;
  fpio_rr_pick #(.N_REQ(N_REQ), .SW(SW)) u_pick (
    .i_eligible(bus.req_valid & req_mask),
    .i_ptr     (r_ptr),
    .o_idx     (w_pick),
    .o_found   (w_found)
  );
  assign w_limit_hit = (r_limit != '0) && (r_cnt == r_limit - 1'b1);
  assign bus.tx_src  = r_grant;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.tx_last   = 1'b0;
    bus.req_ready = '0;
    busy          = r_state == XFER;
    w_next        = (enable && w_found) ? XFER : IDLE;
    if (r_state == XFER) begin
      bus.tx_valid           = bus.req_valid[r_grant];
      bus.tx_data            = bus.req_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
      bus.tx_last            = bus.req_last[r_grant] | w_limit_hit;
      bus.req_ready[r_grant] = bus.tx_ready;
      w_next                 = (bus.req_valid[r_grant] && bus.tx_ready && bus.tx_last) ? IDLE : XFER;
    end
  end
  // The counter saturates so a long unlimited burst never aliases onto a limit.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_limit <= '0;
    end else if (r_state == IDLE) begin
      if (enable && w_found) begin
        r_grant <= w_pick;
        r_cnt   <= '0;
        r_limit <= burst_limit;
      end
    end else if (bus.req_valid[r_grant] && bus.tx_ready) begin
      r_cnt <= &r_cnt ? r_cnt : r_cnt + 1'b1;
      if (bus.tx_last) r_ptr <= (r_grant == SW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
    end
endmodule

// File: tb/tb_fpio_tx_arb.sv
// tb_fpio_tx_arb: randomized sources and a transaction-level scoreboard for fpio_tx_arb
module tb_fpio_tx_arb;
  localparam int N = 4, DW = 4, CW = 8;
  logic clk = 1'b0, rstn = 1'b0, enable = 1'b0, busy;
  logic [CW-1:0] burst_limit = '0;
  logic [N-1:0] req_mask = '1;
  int checks = 0, errors = 0, cyc = 0, pushed = 0;
  logic [DW:0] q[N][$];
  bit rq[$];
  int vprob = 100, rprob = 100;
  int m_busy, m_g, m_ptr, m_cnt, m_lim, n_busy, n_g, n_ptr, n_cnt, n_lim, pop_g = -1;
  bit stall;
  logic [DW-1:0] stall_data;
  int grant_log[$], grant_cyc[$], beat_cyc[$];
  logic [DW:0] beat_log[$];

  fpio_tx_arb_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus();
  fpio_tx_arb #(.N_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .burst_limit(burst_limit),
    .req_mask(req_mask), .busy(busy), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic push_pkt(int i, int len, int base);
    for (int k = 0; k < len; k++) q[i].push_back({k == len - 1, DW'(base + k)});
    pushed += len;
  endtask

  task automatic clr();
    grant_log.delete(); grant_cyc.delete(); beat_cyc.delete(); beat_log.delete();
    pushed = 0;
  endtask

  function automatic int pending();
    int s = m_busy;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() == 0) begin
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
        bus.req_data[i*DW +: DW] = '0;
      end else begin
        bus.req_valid[i] = (bus.req_valid[i] && pop_g != i) || ($urandom_range(0, 99) < vprob);
        bus.req_last[i]  = q[i][0][DW];
        bus.req_data[i*DW +: DW] = q[i][0][DW-1:0];
      end
    end
    bus.tx_ready = rq.size() != 0 ? rq.pop_front() : ($urandom_range(0, 99) < rprob);
  endtask

  // Scoreboard: idle cycles show nothing, the granted requester's head beat is
  // what the transmitter sees, and grants follow round-robin order from the pointer.
  task automatic check();
    logic [N-1:0] elig, exp_rdy;
    logic exp_last;
    n_busy = m_busy; n_g = m_g; n_ptr = m_ptr; n_cnt = m_cnt; n_lim = m_lim; pop_g = -1;
    if (m_busy == 0) begin
      stall = 0;
      checks++;
      if ({busy, bus.tx_valid, bus.tx_last, bus.req_ready} !== '0) begin
        errors++;
        $display("FAIL idle_outputs cyc %0d got busy=%b tx_valid=%b tx_last=%b req_ready=%b want all 0",
                 cyc, busy, bus.tx_valid, bus.tx_last, bus.req_ready);
      end
      elig = bus.req_valid & req_mask;
      if (enable && elig != 0) begin
        for (int k = 0; k < N; k++) if (elig[(m_ptr + k) % N]) begin n_g = (m_ptr + k) % N; break; end
        n_busy = 1; n_cnt = 0; n_lim = int'(burst_limit);
        grant_log.push_back(n_g); grant_cyc.push_back(cyc + 1);
      end
    end else begin
      exp_last = bus.req_last[m_g] || (m_lim != 0 && m_cnt == m_lim - 1);
      exp_rdy = '0;
      exp_rdy[m_g] = bus.tx_ready;
      checks++;
      if ({busy, bus.tx_src, bus.tx_valid, bus.tx_last, bus.req_ready} !==
          {1'b1, 2'(m_g), bus.req_valid[m_g], exp_last, exp_rdy}) begin
        errors++;
        $display("FAIL xfer_outputs cyc %0d got busy/src/valid/last/ready=%b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b",
                 cyc, busy, bus.tx_src, bus.tx_valid, bus.tx_last, bus.req_ready,
                 1'b1, m_g, bus.req_valid[m_g], exp_last, exp_rdy);
      end
      if (bus.req_valid[m_g]) begin
        checks++;
        if (bus.tx_data !== q[m_g][0][DW-1:0]) begin
          errors++;
          $display("FAIL tx_data cyc %0d got %h want %h", cyc, bus.tx_data, q[m_g][0][DW-1:0]);
        end
      end
      if (stall && bus.tx_valid) begin
        checks++;
        if (bus.tx_data !== stall_data) begin
          errors++;
          $display("FAIL stall_hold cyc %0d got %h want %h", cyc, bus.tx_data, stall_data);
        end
      end
      stall = bus.req_valid[m_g] && !bus.tx_ready;
      stall_data = bus.tx_data;
      if (bus.req_valid[m_g] && bus.tx_ready) begin
        pop_g = m_g;
        beat_cyc.push_back(cyc);
        beat_log.push_back({exp_last, q[m_g][0][DW-1:0]});
        n_cnt = m_cnt < 255 ? m_cnt + 1 : m_cnt;
        if (exp_last) begin n_busy = 0; n_ptr = (m_g + 1) % N; stall = 0; end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    m_busy = n_busy; m_g = n_g; m_ptr = n_ptr; m_cnt = n_cnt; m_lim = n_lim;
    if (pop_g >= 0) void'(q[pop_g].pop_front());
    cyc++;
    drive();
    pop_g = -1;
  endtask

  task automatic drain(int maxc);
    int c = 0;
    while (pending() != 0 && c < maxc) begin tick(); c++; end
    tick();
    checks++;
    if (c >= maxc) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending after %0d cycles want 0", pending(), c);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.tx_ready = 1'b1;
    rstn = 1'b0; enable = 1'b1;
    push_pkt(0, 2, 1);
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, bus.tx_valid, bus.tx_last, bus.req_ready, bus.tx_src} !== '0) begin
      errors++;
      $display("FAIL reset_values got busy=%b valid=%b last=%b ready=%b src=%0d want 0",
               busy, bus.tx_valid, bus.tx_last, bus.req_ready, bus.tx_src);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    q[0].delete();
    m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_lim = 0; stall = 0;
    drive();
  endtask

  task automatic test_round_robin();
    clr();
    for (int r = 0; r < 2; r++) for (int i = 0; i < 3; i++) push_pkt(i, 1, i * 4 + r);
    drive();
    drain(100);
    checks++;
    if (grant_log.size() != 6) begin
      errors++;
      $display("FAIL rr_count got %0d want 6", grant_log.size());
    end
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
      checks++;
      if (grant_log[k] != k % 3) begin
        errors++;
        $display("FAIL rr_order[%0d] got %0d want %0d", k, grant_log[k], k % 3);
      end
      if (k > 0) begin
        checks++;
        if (grant_cyc[k] - grant_cyc[k-1] != 2) begin
          errors++;
          $display("FAIL rr_gap[%0d] got %0d want 2", k, grant_cyc[k] - grant_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_single();
    int c0;
    clr();
    c0 = cyc;
    push_pkt(0, 3, 5);
    drive();
    drain(50);
    checks++;
    if (grant_log.size() != 1 || grant_log[0] != 0 || beat_log.size() != 3) begin
      errors++;
      $display("FAIL single_shape got grants=%0d beats=%0d want 1 grant to 0 and 3 beats",
               grant_log.size(), beat_log.size());
    end
    for (int k = 0; k < 3 && k < beat_log.size(); k++) begin
      checks++;
      if (beat_log[k] !== {k == 2, DW'(5 + k)} || beat_cyc[k] != c0 + 1 + k) begin
        errors++;
        $display("FAIL single_beat[%0d] got %h@%0d want %h@%0d", k, beat_log[k], beat_cyc[k],
                 {k == 2, DW'(5 + k)}, c0 + 1 + k);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_after got %b want 0", busy);
    end
  endtask

  task automatic test_burst_limit();
    clr();
    burst_limit = 8'd4;
    push_pkt(1, 10, 0);
    drive();
    drain(200);
    burst_limit = '0;
    checks++;
    if (grant_log.size() != 3 || beat_log.size() != 10) begin
      errors++;
      $display("FAIL limit_shape got grants=%0d beats=%0d want 3 and 10", grant_log.size(), beat_log.size());
    end
    for (int k = 0; k < 3 && k < grant_log.size(); k++) begin
      checks++;
      if (grant_log[k] != 1 || (k > 0 && grant_cyc[k] - grant_cyc[k-1] != 5)) begin
        errors++;
        $display("FAIL limit_grant[%0d] got src %0d at %0d want src 1 spaced 5", k, grant_log[k], grant_cyc[k]);
      end
    end
    for (int k = 0; k < 10 && k < beat_log.size(); k++) begin
      checks++;
      if (beat_log[k] !== {k == 3 || k == 7 || k == 9, DW'(k)}) begin
        errors++;
        $display("FAIL limit_beat[%0d] got %h want %h", k, beat_log[k], {k == 3 || k == 7 || k == 9, DW'(k)});
      end
    end
  endtask

  task automatic test_backpressure();
    int c0;
    int exp_c[4] = '{1, 4, 5, 6};
    clr();
    c0 = cyc;
    push_pkt(3, 4, 8);
    rq = '{1, 1, 0, 0, 1, 1, 1, 1};
    drive();
    drain(50);
    checks++;
    if (beat_log.size() != 4) begin
      errors++;
      $display("FAIL bp_count got %0d want 4", beat_log.size());
    end
    for (int k = 0; k < 4 && k < beat_log.size(); k++) begin
      checks++;
      if (beat_log[k] !== {k == 3, DW'(8 + k)} || beat_cyc[k] != c0 + exp_c[k]) begin
        errors++;
        $display("FAIL bp_beat[%0d] got %h@%0d want %h@%0d", k, beat_log[k], beat_cyc[k],
                 {k == 3, DW'(8 + k)}, c0 + exp_c[k]);
      end
    end
  endtask

  task automatic test_mask_enable();
    int n2 = 0;
    clr();
    req_mask = 4'b1011;
    for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) push_pkt(i, 1, i * 4 + r);
    drive();
    repeat (40) tick();
    foreach (grant_log[k]) if (grant_log[k] == 2) n2++;
    checks++;
    if (n2 != 0 || q[2].size() != 3 || q[0].size() + q[1].size() + q[3].size() != 0) begin
      errors++;
      $display("FAIL mask_block got grants_to_2=%0d q2=%0d others=%0d want 0/3/0",
               n2, q[2].size(), q[0].size() + q[1].size() + q[3].size());
    end
    req_mask = '1;
    drain(100);
    clr();
    push_pkt(0, 6, 0);
    drive();
    for (int c = 0; c < 10 && m_busy == 0; c++) tick();
    repeat (2) tick();
    enable = 1'b0;
    push_pkt(1, 1, 9);
    repeat (12) tick();
    checks++;
    if (grant_log.size() != 1 || beat_log.size() != 6 || busy !== 1'b0 || q[1].size() != 1) begin
      errors++;
      $display("FAIL enable_low got grants=%0d beats=%0d busy=%b q1=%0d want 1/6/0/1",
               grant_log.size(), beat_log.size(), busy, q[1].size());
    end
    enable = 1'b1;
    drain(50);
    checks++;
    if (grant_log.size() != 2 || grant_log[grant_log.size()-1] != 1) begin
      errors++;
      $display("FAIL enable_resume got grants=%0d want 2 ending with src 1", grant_log.size());
    end
  endtask

  task automatic test_reset_mid();
    clr();
    push_pkt(2, 5, 3);
    drive();
    for (int c = 0; c < 10 && beat_log.size() < 1; c++) tick();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.tx_valid, bus.req_ready, busy, bus.tx_src} !== '0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b ready=%b busy=%b src=%0d want 0",
               bus.tx_valid, bus.req_ready, busy, bus.tx_src);
    end
    m_busy = 0; m_ptr = 0; m_cnt = 0; m_g = 0; stall = 0; pop_g = -1;
    for (int i = 0; i < N; i++) q[i].delete();
    clr();
    push_pkt(3, 1, 7);
    push_pkt(1, 1, 6);
    drive();
    @(posedge clk);
    #1 rstn = 1'b1;
    drain(50);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 3) begin
      errors++;
      $display("FAIL reset_ptr got grants=%0d first=%0d want 1 then 3", grant_log.size(), grant_log[0]);
    end
  endtask

  task automatic test_random();
    clr();
    vprob = 70; rprob = 60;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0)
        push_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 6)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 15) == 0) req_mask = N'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) enable = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 15) == 0) burst_limit = CW'($urandom_range(0, 5));
      tick();
    end
    enable = 1'b1; req_mask = '1;
    drain(4000);
    checks++;
    if (beat_log.size() != pushed) begin
      errors++;
      $display("FAIL random_total got %0d beats want %0d", beat_log.size(), pushed);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_burst_limit();
    test_backpressure();
    test_mask_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
